// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state encoding and the size-to-byte-count helper.
package data_memory_responder_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_BITS  = BLOCK_BYTES * 8;

    // Size codes match the LSU load/store format field.
    localparam logic [2:0] SIZE_BYTE  = 3'd1;
    localparam logic [2:0] SIZE_HALF  = 3'd2;
    localparam logic [2:0] SIZE_WORD  = 3'd3;
    localparam logic [2:0] SIZE_DWORD = 3'd4;
    localparam logic [2:0] SIZE_QUAD  = 3'd5;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_RESP
    } state_e;

    // Unsupported codes (0, 6, 7) map to zero bytes so callers can flag them.
    function automatic logic [4:0] bytesForSize(input logic [2:0] size);
        case (size)
            SIZE_BYTE:  return 5'd1;
            SIZE_HALF:  return 5'd2;
            SIZE_WORD:  return 5'd4;
            SIZE_DWORD: return 5'd8;
            SIZE_QUAD:  return 5'd16;
            default:    return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Byte-lane extract and merge for one 16-byte block (big-endian bit order,
// byte k at bits [8k +: 8]); also flags illegal size or block-crossing accesses.
module dmem_lane_merge
    import data_memory_responder_pkg::*;
(
    input  logic [0:BLOCK_BITS-1] block,
    input  logic [3:0]            offset,
    input  logic [2:0]            size,
    input  logic [0:BLOCK_BITS-1] store_data,
    output logic [0:BLOCK_BITS-1] load_data,
    output logic [0:BLOCK_BITS-1] merged_block,
    output logic                  misalign
);

    int num_bytes;
    int first_byte;

    // Block byte (offset + j) pairs with right-justified slot (16 - n + j).
    always_comb begin
        num_bytes    = int'(bytesForSize(size));
        first_byte   = int'(offset);
        misalign     = (num_bytes == 0) || (first_byte + num_bytes > BLOCK_BYTES);
        load_data    = '0;
        merged_block = block;
        if (!misalign) begin
            for (int k = 0; k < BLOCK_BYTES; k++) begin
                if (k >= first_byte && k < first_byte + num_bytes) begin
                    merged_block[8*k +: 8] =
                        store_data[8*(BLOCK_BYTES - num_bytes + k - first_byte) +: 8];
                    load_data[8*(BLOCK_BYTES - num_bytes + k - first_byte) +: 8] =
                        block[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Responder side of the LSU data-memory interface: owns the 2 KiB block array,
// clears it after reset, and serves one load/store at a time.
// Optional macro DMEM_BOUNDS_CHECK_EN rejects addresses beyond the array.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int memoryBlockSize = 128,
    parameter int numMemoryBlocks = 128,
    parameter int addressSize     = 64,
    parameter int tagWidth        = 6
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       requestValid_i,
    output logic                       requestReady_o,
    input  logic                       requestIsStore_i,
    input  logic [2:0]                 requestSize_i,
    input  logic [0:addressSize-1]     requestAddress_i,
    input  logic [0:memoryBlockSize-1] storeData_i,
    input  logic [tagWidth-1:0]        requestTag_i,
    output logic                       responseValid_o,
    output logic                       responseIsStore_o,
    output logic [tagWidth-1:0]        responseTag_o,
    output logic [0:memoryBlockSize-1] loadData_o,
    output logic                       responseError_o,
    output logic                       initBusy_o
);

    localparam int IDX_W   = $clog2(numMemoryBlocks);
    localparam int IDX_POS = addressSize - 4 - IDX_W;

    state_e                     state;
    state_e                     next_state;
    logic [IDX_W-1:0]           init_count;
    logic                       accept;
    logic                       addr_oob;

    logic                       req_is_store;
    logic [2:0]                 req_size;
    logic [IDX_W-1:0]           req_index;
    logic [3:0]                 req_offset;
    logic [0:memoryBlockSize-1] req_store_data;
    logic [tagWidth-1:0]        req_tag;
    logic                       req_oob;
    logic                       resp_error;

    logic [0:memoryBlockSize-1] mem [numMemoryBlocks];
    logic [0:memoryBlockSize-1] block_buffer;
    logic                       mem_we;
    logic [IDX_W-1:0]           mem_waddr;
    logic [0:memoryBlockSize-1] mem_wdata;

    logic [0:memoryBlockSize-1] extracted;
    logic [0:memoryBlockSize-1] merged;
    logic                       misalign;

    assign accept = (state == ST_IDLE) && requestValid_i;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign addr_oob = |requestAddress_i[0:IDX_POS-1];
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^requestAddress_i[0:IDX_POS-1];
    assign addr_oob         = 1'b0;
`endif

    dmem_lane_merge lane_merge (
        .block        (block_buffer),
        .offset       (req_offset),
        .size         (req_size),
        .store_data   (req_store_data),
        .load_data    (extracted),
        .merged_block (merged),
        .misalign     (misalign)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state      <= ST_INIT;
            init_count <= '0;
        end else begin
            state <= next_state;
            if (state == ST_INIT) begin
                init_count <= init_count + IDX_W'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_INIT: if (init_count == IDX_W'(numMemoryBlocks - 1)) next_state = ST_IDLE;
            ST_IDLE: if (accept) next_state = ST_READ;
            ST_READ: next_state = ST_RESP;
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_INIT;
        endcase
    end

    // The error verdict is taken in READ so RESP only has to consult one flag.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            req_is_store   <= 1'b0;
            req_size       <= '0;
            req_index      <= '0;
            req_offset     <= '0;
            req_store_data <= '0;
            req_tag        <= '0;
            req_oob        <= 1'b0;
            resp_error     <= 1'b0;
        end else begin
            if (accept) begin
                req_is_store   <= requestIsStore_i;
                req_size       <= requestSize_i;
                req_index      <= requestAddress_i[IDX_POS +: IDX_W];
                req_offset     <= requestAddress_i[addressSize-4 +: 4];
                req_store_data <= storeData_i;
                req_tag        <= requestTag_i;
                req_oob        <= addr_oob;
            end
            if (state == ST_READ) begin
                resp_error <= misalign | req_oob;
            end
        end
    end

    // Gating on reset_i keeps a store caught by reset from reaching the array.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = init_count;
        mem_wdata = '0;
        if (!reset_i) begin
            if (state == ST_INIT) begin
                mem_we = 1'b1;
            end else if (state == ST_RESP && req_is_store && !resp_error) begin
                mem_we    = 1'b1;
                mem_waddr = req_index;
                mem_wdata = merged;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (state == ST_READ) begin
            block_buffer <= mem[req_index];
        end
    end

    assign requestReady_o    = (state == ST_IDLE);
    assign initBusy_o        = (state == ST_INIT);
    assign responseValid_o   = (state == ST_RESP);
    assign responseIsStore_o = (state == ST_RESP) && req_is_store;
    assign responseTag_o     = (state == ST_RESP) ? req_tag : '0;
    assign responseError_o   = (state == ST_RESP) && resp_error;
    assign loadData_o        = (state == ST_RESP && !req_is_store && !resp_error) ? extracted : '0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder: init sweep, byte-accurate
// loads/stores, alignment errors, reset mid-request and address wrap/bounds.
module tb_data_memory_responder;

    logic         clock = 1'b0;
    logic         reset;
    logic         request_valid;
    logic         request_ready;
    logic         request_is_store;
    logic [2:0]   request_size;
    logic [0:63]  request_address;
    logic [0:127] store_data;
    logic [5:0]   request_tag;
    logic         response_valid;
    logic         response_is_store;
    logic [5:0]   response_tag;
    logic [0:127] load_data;
    logic         response_error;
    logic         init_busy;

    int           check_count = 0;
    int           error_count = 0;
    logic [0:127] last_data;
    logic         last_error;

    localparam logic [127:0] BLOCK0  = 128'hCAFEF00D12345678_0000000000000000;
    localparam logic [127:0] QUAD_30 = 128'h00112233445566778899AABBCCDDEEFF;

    always #5 clock = ~clock;

    data_memory_responder dut (
        .clock_i           (clock),
        .reset_i           (reset),
        .requestValid_i    (request_valid),
        .requestReady_o    (request_ready),
        .requestIsStore_i  (request_is_store),
        .requestSize_i     (request_size),
        .requestAddress_i  (request_address),
        .storeData_i       (store_data),
        .requestTag_i      (request_tag),
        .responseValid_o   (response_valid),
        .responseIsStore_o (response_is_store),
        .responseTag_o     (response_tag),
        .loadData_o        (load_data),
        .responseError_o   (response_error),
        .initBusy_o        (init_busy)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic driveRequest(input logic is_store, input logic [2:0] size,
                                input logic [63:0] address, input logic [127:0] data,
                                input logic [5:0] tag);
        request_valid    = 1'b1;
        request_is_store = is_store;
        request_size     = size;
        request_address  = address;
        store_data       = data;
        request_tag      = tag;
    endtask

    // Waits for the handshake, then expects nothing at T+1 and the response at T+2.
    task automatic completeRequest(input string name, input logic is_store,
                                   input logic [5:0] tag);
        int waited = 0;
        while (request_ready !== 1'b1 && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        if (request_ready !== 1'b1) begin
            checkOutput({name, "_ready_timeout"}, 0, 1);
            request_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1 request_valid = 1'b0;
        @(negedge clock);
        checkOutput({name, "_t1_valid"}, response_valid, 0);
        @(negedge clock);
        checkOutput({name, "_t2_valid"}, response_valid, 1);
        checkOutput({name, "_tag"}, response_tag, tag);
        checkOutput({name, "_is_store"}, response_is_store, is_store);
        last_data  = load_data;
        last_error = response_error;
        @(posedge clock);
        #1 checkOutput({name, "_pulse_end"}, response_valid, 0);
    endtask

    task automatic applyStimulus(input string name, input logic is_store,
                                 input logic [2:0] size, input logic [63:0] address,
                                 input logic [127:0] data, input logic [5:0] tag,
                                 input logic [127:0] exp_data, input logic exp_error);
        driveRequest(is_store, size, address, data, tag);
        completeRequest(name, is_store, tag);
        checkOutput({name, "_data"}, last_data, exp_data);
        checkOutput({name, "_error"}, last_error, exp_error);
    endtask

    task automatic runInitSweep(input string name);
        int busy_cycles = 0;
        int ready_seen  = 0;
        int resp_seen   = 0;
        while (init_busy === 1'b1 && busy_cycles < 1000) begin
            if (request_ready === 1'b1) ready_seen++;
            if (response_valid === 1'b1) resp_seen++;
            busy_cycles++;
            @(negedge clock);
        end
        checkOutput({name, "_busy_cycles"}, busy_cycles, 128);
        checkOutput({name, "_ready_in_init"}, ready_seen, 0);
        checkOutput({name, "_resp_in_init"}, resp_seen, 0);
        checkOutput({name, "_ready_after"}, request_ready, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        driveRequest(1'b0, 3'd4, 64'h40, '0, 6'h01);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_ready", request_ready, 0);
        checkOutput("rst_busy", init_busy, 1);
        checkOutput("rst_valid", response_valid, 0);
        checkOutput("rst_is_store", response_is_store, 0);
        checkOutput("rst_tag", response_tag, 0);
        checkOutput("rst_data", load_data, 0);
        checkOutput("rst_error", response_error, 0);
        reset = 1'b0;
        runInitSweep("init1");
        completeRequest("t1_load40", 1'b0, 6'h01);
        checkOutput("t1_load40_data", last_data, 0);
        checkOutput("t1_load40_error", last_error, 0);

        applyStimulus("t2_st_byte13", 1'b1, 3'd1, 64'h13, 128'hAB, 6'h02, 0, 1'b0);
        applyStimulus("t2_ld_dword10", 1'b0, 3'd4, 64'h10, '0, 6'h03,
                      128'h000000AB00000000, 1'b0);

        applyStimulus("t3_st_word24", 1'b1, 3'd3, 64'h24, 128'hDEADBEEF, 6'h04, 0, 1'b0);
        applyStimulus("t3_ld_half26", 1'b0, 3'd2, 64'h26, '0, 6'h05, 128'hBEEF, 1'b0);
        applyStimulus("t3_ld_word20", 1'b0, 3'd3, 64'h20, '0, 6'h06, 0, 1'b0);
        applyStimulus("t3_ld_dword28", 1'b0, 3'd4, 64'h28, '0, 6'h07, 0, 1'b0);

        applyStimulus("t4_st_quad30", 1'b1, 3'd5, 64'h30, QUAD_30, 6'h08, 0, 1'b0);
        applyStimulus("t4_ld_quad30", 1'b0, 3'd5, 64'h30, '0, 6'h09, QUAD_30, 1'b0);
        applyStimulus("t4_ld_quad38", 1'b0, 3'd5, 64'h38, '0, 6'h0A, 0, 1'b1);
        applyStimulus("t4_st_half32", 1'b1, 3'd2, 64'h32, 128'h1234, 6'h0B, 0, 1'b0);
        applyStimulus("t4_ld_quad30b", 1'b0, 3'd5, 64'h30, '0, 6'h0C,
                      128'h00111234445566778899AABBCCDDEEFF, 1'b0);

        applyStimulus("t5_st_dword00", 1'b1, 3'd4, 64'h00, 128'hCAFEF00D12345678, 6'h0D, 0, 1'b0);
        applyStimulus("t5_ld_word0e", 1'b0, 3'd3, 64'h0E, '0, 6'h15, 0, 1'b1);
        applyStimulus("t5_st_dword0c", 1'b1, 3'd4, 64'h0C, 128'h1122334455667788, 6'h16, 0, 1'b1);
        applyStimulus("t5_ld_quad00", 1'b0, 3'd5, 64'h00, '0, 6'h17, BLOCK0, 1'b0);

        applyStimulus("sz0_load", 1'b0, 3'd0, 64'h40, '0, 6'h18, 0, 1'b1);
        applyStimulus("sz6_load", 1'b0, 3'd6, 64'h40, '0, 6'h19, 0, 1'b1);
        applyStimulus("sz7_store", 1'b1, 3'd7, 64'h40, {128{1'b1}}, 6'h1A, 0, 1'b1);
        applyStimulus("sz7_check", 1'b0, 3'd5, 64'h40, '0, 6'h1B, 0, 1'b0);

`ifdef DMEM_BOUNDS_CHECK_EN
        applyStimulus("t7_ld_oob800", 1'b0, 3'd5, 64'h800, '0, 6'h1C, 0, 1'b1);
`else
        applyStimulus("t8_ld_wrap800", 1'b0, 3'd5, 64'h800, '0, 6'h1C, BLOCK0, 1'b0);
`endif

        driveRequest(1'b1, 3'd1, 64'h50, 128'h5A, 6'h1D);
        @(posedge clock);
        #1 request_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1 checkOutput("t6_no_resp", response_valid, 0);
        checkOutput("t6_busy", init_busy, 1);
        @(negedge clock);
        reset = 1'b0;
        runInitSweep("init2");
        applyStimulus("t6_ld_byte50", 1'b0, 3'd1, 64'h50, '0, 6'h1E, 0, 1'b0);
        applyStimulus("t6_ld_quad00", 1'b0, 3'd5, 64'h00, '0, 6'h1F, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder side of the load/store unit's data-memory interface.
- Owns the D-memory array: 128 blocks of 128 bits, 2 KiB.
- Accepts one load or store request at a time over a valid/ready handshake.
- Performs block read, byte-lane extract or merge, and write. Returns a single-cycle response carrying load data or store acknowledge, plus the echoed request tag.

Parameters:
- memoryBlockSize, 128, block width in bits; 16 bytes per block.
- numMemoryBlocks, 128, number of blocks (power of two).
- addressSize, 64, byte-address width.
- tagWidth, 6, opaque request tag width (writeback register address).

Ports:
- clock_i  in  1  single clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- requestValid_i  in  1  request present.
- requestReady_o  out  1  responder can accept this cycle.
- requestIsStore_i  in  1  1 = store, 0 = load.
- requestSize_i  in  3  1 = byte, 2 = half, 3 = word, 4 = dword, 5 = quad.
- requestAddress_i  in  addressSize  byte address.
- storeData_i  in  128  store data, right-justified (bit 127 = LSB).
- requestTag_i  in  tagWidth  echoed on response.
- responseValid_o  out  1  one-cycle response pulse.
- responseIsStore_o  out  1  response belongs to a store.
- responseTag_o  out  tagWidth  echoed tag.
- loadData_o  out  128  load data, right-justified, zero-filled above size; 0 for stores.
- responseError_o  out  1  access rejected; memory unchanged.
- initBusy_o  out  1  memory clear sweep in progress.

Behaviour:
- Bit numbering is big-endian: bit 0 is the MSB. Byte offset k of a block occupies bits [8k +: 8].
- Address decode:
  - Block index = address[addressSize-11 +: 7], i.e. (address/16) mod numMemoryBlocks.
  - Offset = address mod 16.
- States:
  - INIT: clear sweep, one block per cycle; a 7-bit counter runs 0..numMemoryBlocks-1, then goes to IDLE.
  - IDLE: requestReady_o = 1; a handshake (valid & ready) latches request fields and goes to READ.
  - READ: registered array read of the addressed block into a buffer; goes to RESP.
  - RESP:
    - Load: extract and right-justify the addressed bytes.
    - Store: merge the addressed bytes of storeData_i into the buffer, then write the whole block back.
    - Assert responseValid_o for one cycle; go to IDLE.
- Latency: request accepted at cycle T, response at T+2. The next request can be accepted at T+3. requestReady_o = 1 only in IDLE.
- Size/alignment rules, checked on the latched request in READ:
  - Error if offset + bytes(size) > 16, i.e. the access crosses a block.
  - Error if size is 0, 6 or 7.
  - Quad requires offset 0.
  - On error: response at T+2 with responseError_o = 1, loadData_o = 0, no write.
- Byte-accurate stores: only the addressed bytes change; the other 16 - n bytes of the block are preserved.
- The response has no backpressure; the LSU must sink it.
- Reset, asserted in any state including mid-request:
  - Next state is INIT with the counter at 0.
  - Any in-flight request is dropped with no response. A pending store is not written.
  - INIT takes numMemoryBlocks cycles. initBusy_o = 1 and requestReady_o = 0 throughout.
- Output reset values: requestReady_o 0, responseValid_o 0, responseIsStore_o 0, responseTag_o 0, loadData_o 0, responseError_o 0, initBusy_o 1.
- A request presented during INIT is not accepted; requestValid_i is held by the initiator.

Optional Feature:
- Macro DMEM_BOUNDS_CHECK_EN.
- Defined: an address ≥ numMemoryBlocks*16 gives responseError_o = 1, no access, latency unchanged.
- Undefined: upper address bits are ignored and the block index wraps modulo numMemoryBlocks.

Decomposition:
- Shared package holds:
  - Size codes (SIZE_BYTE..SIZE_QUAD, matching the LSU load/store format codes).
  - State encoding: INIT, IDLE, READ, RESP.
  - BLOCK_BYTES = 16.
  - Function bytesForSize().
- One combinational sub-module, dmem_lane_merge:
  - Inputs: block, offset, size, store data.
  - Outputs: extracted right-justified load data, merged block, misalign flag.
- Array, FSM and handshake stay in data_memory_responder.

Test Plan:
1. Reset, then valid held from cycle 0 → initBusy_o high 128 cycles, ready rises at cycle 128. A load of address 0x40 then returns 0.
2. Store byte 0xAB at address 0x13, then load dword at 0x10 → store response at T+2, no error. The load returns 0x000000AB00000000 in bits 64..127.
3. Store word 0xDEADBEEF at 0x24, then load half at 0x26 → load returns 0xBEEF, zero-extended. Bytes 0x20..0x23 and 0x28..0x2F remain 0.
4. Store quad at 0x30 with pattern 0x00112233..EEFF, then load quad at 0x30 → identical 128 bits. Load quad at 0x38 → responseError_o = 1.
5. Load word at 0x0E (crosses block) → error at T+2, tag echoed (e.g. 0x15). Then store dword at 0x0C → error, and block 0 is unchanged.
6. Reset asserted in READ of a store to 0x50 → no response. After INIT, a load of 0x50 returns 0.
7. With DMEM_BOUNDS_CHECK_EN, a load at 0x800 → error.
8. Without DMEM_BOUNDS_CHECK_EN, a load at 0x800 returns the contents of address 0x0.
